// File: rtl/dma_program_master.sv
// dma_program_master: CPU-side initiator that programs the DMA controller's
// register file over the 8-bit slave bus. Each command becomes one bus cycle,
// or three for the 16-bit registers (clear flip-flop, low byte, high byte).
module dma_program_master #(
   parameter int unsigned STROBE_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [2:0]  cmdOp,
   input  logic [1:0]  cmdChannel,
   input  logic [15:0] cmdWdata,
   output logic        rspValid,
   output logic [15:0] rspRdata,
   output logic        CS_N,
   output logic        IOR_N,
   output logic        IOW_N,
   output logic        A3,
   output logic        A2,
   output logic        A1,
   output logic        A0,
   output logic [7:0]  dbOut,
   output logic        dbOe,
   input  logic [7:0]  dbIn,
   output logic        programCondition
);

   if (STROBE_CYCLES < 1) begin : g_bad_strobe
      $error("STROBE_CYCLES must be at least 1");
   end

   localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q;
   logic [1:0]  ch_q;
   logic [15:0] wdata_q;
   logic [1:0]  phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        cur_write_q, write_d;
   logic [7:0]  rd_lo_q, rd_hi_q;
   logic [3:0]  addr_q, addr_d;
   logic        accept, op16_q;
   logic [2:0]  dec_op;
   logic [1:0]  dec_ch;
   logic [15:0] dec_wdata;
   logic        dec_is16, dec_write;
   logic [3:0]  dec_addr;
   logic [7:0]  dec_byte, dout_d;
   logic        cs_d, ior_d, iow_d, oe_d, pc_d, rsp_d;

   assign cmdReady = (state_q == IDLE) && !RESET;
   assign accept   = cmdValid && cmdReady;
   assign op16_q   = (op_q >= 3'd2) && (op_q <= 3'd5);
   assign {A3, A2, A1, A0} = addr_q;

   // Sequence SETUP/STROBE/RECOVER per bus cycle and step the 16-bit phase.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
               phase_d = 2'd0;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = '0;
         end
         STROBE: begin
            if (cnt_q == CNT_LAST) state_d = RECOVER;
            else cnt_d = cnt_q + 1'b1;
         end
         RECOVER: begin
            if (op16_q && phase_q != 2'd2) begin
               state_d = SETUP;
               phase_d = phase_q + 2'd1;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decode the register address, direction and data byte of the upcoming bus cycle.
   always_comb begin
      dec_op    = accept ? cmdOp : op_q;
      dec_ch    = accept ? cmdChannel : ch_q;
      dec_wdata = accept ? cmdWdata : wdata_q;
      dec_is16  = (dec_op >= 3'd2) && (dec_op <= 3'd5);
      dec_addr  = 4'b0000;
      dec_write = 1'b1;
      dec_byte  = 8'h00;
      if (dec_is16 && phase_d == 2'd0) begin
         dec_addr = 4'b1100;
      end else begin
         case (dec_op)
            3'd0: begin dec_addr = 4'b1000; dec_byte = dec_wdata[7:0]; end
            3'd1: begin dec_addr = 4'b1011; dec_byte = dec_wdata[7:0]; end
            3'd6: begin dec_addr = 4'b1000; dec_write = 1'b0; end
            3'd7: dec_addr = 4'b1100;
            default: begin
               dec_addr  = {1'b0, dec_ch, dec_op[0]};
               dec_write = !dec_op[2];
               if (dec_write)
                  dec_byte = (phase_d == 2'd2) ? dec_wdata[15:8] : dec_wdata[7:0];
            end
         endcase
      end
   end

   // Next values of the registered bus outputs, keyed on the state being entered.
   always_comb begin
      cs_d    = 1'b1;
      ior_d   = 1'b1;
      iow_d   = 1'b1;
      oe_d    = 1'b0;
      pc_d    = 1'b0;
      rsp_d   = 1'b0;
      addr_d  = addr_q;
      dout_d  = dbOut;
      write_d = cur_write_q;
      case (state_d)
         SETUP: begin
            cs_d    = 1'b0;
            addr_d  = dec_addr;
            dout_d  = dec_write ? dec_byte : 8'h00;
            oe_d    = dec_write;
            write_d = dec_write;
            pc_d    = 1'b1;
         end
         STROBE: begin
            cs_d  = 1'b0;
            iow_d = !cur_write_q;
            ior_d = cur_write_q;
            oe_d  = cur_write_q;
            pc_d  = 1'b1;
         end
         RECOVER: pc_d = 1'b1;
         DONE:    rsp_d = 1'b1;
         default: ;
      endcase
   end

   // State, captured command, read bytes and all registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q          <= IDLE;
         op_q             <= 3'd0;
         ch_q             <= 2'd0;
         wdata_q          <= 16'h0000;
         phase_q          <= 2'd0;
         cnt_q            <= '0;
         cur_write_q      <= 1'b0;
         rd_lo_q          <= 8'h00;
         rd_hi_q          <= 8'h00;
         addr_q           <= 4'b0000;
         dbOut            <= 8'h00;
         dbOe             <= 1'b0;
         CS_N             <= 1'b1;
         IOR_N            <= 1'b1;
         IOW_N            <= 1'b1;
         programCondition <= 1'b0;
         rspValid         <= 1'b0;
         rspRdata         <= 16'h0000;
      end else begin
         state_q          <= state_d;
         phase_q          <= phase_d;
         cnt_q            <= cnt_d;
         cur_write_q      <= write_d;
         addr_q           <= addr_d;
         dbOut            <= dout_d;
         dbOe             <= oe_d;
         CS_N             <= cs_d;
         IOR_N            <= ior_d;
         IOW_N            <= iow_d;
         programCondition <= pc_d;
         rspValid         <= rsp_d;
         if (accept) begin
            op_q     <= cmdOp;
            ch_q     <= cmdChannel;
            wdata_q  <= cmdWdata;
            rd_lo_q  <= 8'h00;
            rd_hi_q  <= 8'h00;
            rspRdata <= 16'h0000;
         end
         if (state_q == STROBE && cnt_q == CNT_LAST && !cur_write_q) begin
            if (phase_q == 2'd2) rd_hi_q <= dbIn;
            else rd_lo_q <= dbIn;
         end
         if (state_d == DONE) begin
            case (op_q)
               3'd4, 3'd5: rspRdata <= {rd_hi_q, rd_lo_q};
               3'd6:       rspRdata <= {8'h00, rd_lo_q};
               default:    rspRdata <= 16'h0000;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dma_program_master.sv
// tb_dma_program_master: checks two instances (STROBE_CYCLES 2 and 1) against
// a cycle-position model of the programming bus.
module tb_dma_program_master;

   logic CLK = 1'b0;
   logic RESET, cmdValid, sel;
   logic [2:0]  cmdOp;
   logic [1:0]  cmdChannel;
   logic [15:0] cmdWdata;
   logic [7:0]  dbIn;

   logic [1:0] readyW, rspW, csW, iorW, iowW, oeW, pcW;
   logic [1:0][15:0] rdataW;
   logic [1:0][3:0]  addrW;
   logic [1:0][7:0]  doutW;

   logic obsReady, obsRsp, obsCs, obsIor, obsIow, obsOe, obsPc;
   logic [15:0] obsRdata;
   logic [3:0]  obsAddr;
   logic [7:0]  obsDout;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  ch;
      logic [15:0] wdata;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] rdata;
   } vec_t;

   // Free-running clock shared by both instances.
   always #5 CLK = ~CLK;

   assign obsReady = readyW[sel];
   assign obsRsp   = rspW[sel];
   assign obsCs    = csW[sel];
   assign obsIor   = iorW[sel];
   assign obsIow   = iowW[sel];
   assign obsOe    = oeW[sel];
   assign obsPc    = pcW[sel];
   assign obsRdata = rdataW[sel];
   assign obsAddr  = addrW[sel];
   assign obsDout  = doutW[sel];

   dma_program_master #(.STROBE_CYCLES(2)) dutA (
      .CLK(CLK), .RESET(RESET), .cmdValid(cmdValid & !sel), .cmdReady(readyW[0]),
      .cmdOp(cmdOp), .cmdChannel(cmdChannel), .cmdWdata(cmdWdata),
      .rspValid(rspW[0]), .rspRdata(rdataW[0]), .CS_N(csW[0]), .IOR_N(iorW[0]),
      .IOW_N(iowW[0]), .A3(addrW[0][3]), .A2(addrW[0][2]), .A1(addrW[0][1]),
      .A0(addrW[0][0]), .dbOut(doutW[0]), .dbOe(oeW[0]), .dbIn(dbIn),
      .programCondition(pcW[0]));

   dma_program_master #(.STROBE_CYCLES(1)) dutB (
      .CLK(CLK), .RESET(RESET), .cmdValid(cmdValid & sel), .cmdReady(readyW[1]),
      .cmdOp(cmdOp), .cmdChannel(cmdChannel), .cmdWdata(cmdWdata),
      .rspValid(rspW[1]), .rspRdata(rdataW[1]), .CS_N(csW[1]), .IOR_N(iorW[1]),
      .IOW_N(iowW[1]), .A3(addrW[1][3]), .A2(addrW[1][2]), .A1(addrW[1][1]),
      .A0(addrW[1][0]), .dbOut(doutW[1]), .dbOe(oeW[1]), .dbIn(dbIn),
      .programCondition(pcW[1]));

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int busCount(input logic [2:0] op);
      return (op >= 3'd2 && op <= 3'd5) ? 3 : 1;
   endfunction

   // {write, address, byte} of bus cycle b of a command.
   function automatic logic [12:0] busInfo(input logic [2:0] op, input logic [1:0] ch,
                                           input logic [15:0] wdata, input int b);
      logic w;
      if (busCount(op) == 3) begin
         if (b == 0) return {1'b1, 4'b1100, 8'h00};
         w = (op == 3'd2 || op == 3'd3);
         return {w, 1'b0, ch, (op == 3'd3 || op == 3'd5),
                 w ? ((b == 1) ? wdata[7:0] : wdata[15:8]) : 8'h00};
      end
      case (op)
         3'd0:    return {1'b1, 4'b1000, wdata[7:0]};
         3'd1:    return {1'b1, 4'b1011, wdata[7:0]};
         3'd6:    return {1'b0, 4'b1000, 8'h00};
         default: return {1'b1, 4'b1100, 8'h00};
      endcase
   endfunction

   function automatic logic [15:0] expRdata(input logic [2:0] op, input logic [7:0] lo,
                                            input logic [7:0] hi);
      if (op == 3'd4 || op == 3'd5) return {hi, lo};
      if (op == 3'd6) return {8'h00, lo};
      return 16'h0000;
   endfunction

   // Issue one command on the selected instance and check every cycle until it is idle again.
   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] ch, input logic [15:0] wdata,
                                input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] expR);
      int s, l, n, b, pos;
      logic [12:0] info;
      logic w;
      logic [10:0] expBus;
      s = sel ? 1 : 2;
      l = s + 2;
      n = busCount(op);
      @(negedge CLK);
      checkOutput("ready_before", {15'd0, obsReady}, 16'd1);
      cmdValid = 1'b1; cmdOp = op; cmdChannel = ch; cmdWdata = wdata;
      dbIn = 8'($urandom);
      for (int k = 1; k <= n * l + 2; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            cmdValid = 1'b0;
            cmdOp = 3'($urandom); cmdChannel = 2'($urandom); cmdWdata = 16'($urandom);
         end
         if (k <= n * l) begin
            b = (k - 1) / l;
            pos = (k - 1) % l;
            info = busInfo(op, ch, wdata, b);
            w = info[12];
            expBus = {(pos <= s) ? 1'b0 : 1'b1,
                      (!w && pos >= 1 && pos <= s) ? 1'b0 : 1'b1,
                      (w && pos >= 1 && pos <= s) ? 1'b0 : 1'b1,
                      w && (pos <= s), 1'b1, 1'b0, 1'b0, info[11:8]};
            checkOutput($sformatf("op%0d s%0d k%0d bus", op, s, k),
                        {5'd0, obsCs, obsIor, obsIow, obsOe, obsPc, obsRsp, obsReady, obsAddr},
                        {5'd0, expBus});
            if (w && pos <= s)
               checkOutput($sformatf("op%0d s%0d k%0d dbOut", op, s, k), {8'd0, obsDout}, {8'd0, info[7:0]});
            if (!w && pos == s) dbIn = (b == 2) ? hi : lo;
            else if (pos >= 1 && pos < s) dbIn = 8'hFF;
            else dbIn = 8'($urandom);
         end else if (k == n * l + 1) begin
            checkOutput($sformatf("op%0d s%0d done ctl", op, s),
                        {9'd0, obsCs, obsIor, obsIow, obsOe, obsPc, obsRsp, obsReady},
                        {9'd0, 7'b1110010});
            checkOutput($sformatf("op%0d s%0d rdata", op, s), obsRdata, expR);
         end else begin
            checkOutput($sformatf("op%0d s%0d idle ctl", op, s),
                        {9'd0, obsCs, obsIor, obsIow, obsOe, obsPc, obsRsp, obsReady},
                        {9'd0, 7'b1110001});
            checkOutput($sformatf("op%0d s%0d rdata held", op, s), obsRdata, expR);
         end
      end
   endtask

   // Main sequence: reset, table vectors, mid-command reset, back-to-back, random.
   initial begin
      vec_t tbl[8];
      int rspCnt, readyCyc, rsp1, rsp2;
      logic [2:0] rop;
      logic [7:0] rlo, rhi;

      tbl[0] = '{3'd0, 2'd0, 16'h0044, 8'h00, 8'h00, 16'h0000};
      tbl[1] = '{3'd2, 2'd2, 16'hBEEF, 8'h00, 8'h00, 16'h0000};
      tbl[2] = '{3'd5, 2'd1, 16'h0000, 8'h34, 8'h12, 16'h1234};
      tbl[3] = '{3'd6, 2'd0, 16'h0000, 8'h0F, 8'h00, 16'h000F};
      tbl[4] = '{3'd1, 2'd0, 16'h0056, 8'h00, 8'h00, 16'h0000};
      tbl[5] = '{3'd7, 2'd3, 16'hFFFF, 8'h00, 8'h00, 16'h0000};
      tbl[6] = '{3'd4, 2'd3, 16'h0000, 8'hAB, 8'hCD, 16'hCDAB};
      tbl[7] = '{3'd3, 2'd0, 16'h1357, 8'h00, 8'h00, 16'h0000};

      RESET = 1'b1; cmdValid = 1'b0; sel = 1'b0;
      cmdOp = 3'd0; cmdChannel = 2'd0; cmdWdata = 16'h0000; dbIn = 8'h00;
      repeat (3) @(negedge CLK);
      checkOutput("reset bus", {5'd0, obsCs, obsIor, obsIow, obsOe, obsPc, obsRsp, obsReady, obsAddr},
                  {5'd0, 11'b11100000000});
      checkOutput("reset dbOut", {8'd0, obsDout}, 16'h0000);
      checkOutput("reset rdata", obsRdata, 16'h0000);
      RESET = 1'b0;

      for (int i = 0; i < 8; i++)
         applyStimulus(tbl[i].op, tbl[i].ch, tbl[i].wdata, tbl[i].lo, tbl[i].hi, tbl[i].rdata);

      @(negedge CLK);
      cmdValid = 1'b1; cmdOp = 3'd1; cmdWdata = 16'h0077;
      repeat (3) @(negedge CLK);
      cmdValid = 1'b0;
      checkOutput("mid strobe iow", {15'd0, obsIow}, 16'd0);
      RESET = 1'b1;
      #1;
      checkOutput("async reset ctl", {11'd0, obsCs, obsIow, obsOe, obsReady, obsPc}, {11'd0, 5'b11000});
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      checkOutput("ready after reset", {15'd0, obsReady}, 16'd1);
      rspCnt = 0;
      repeat (6) begin
         @(negedge CLK);
         if (obsRsp) rspCnt++;
      end
      checkOutput("no rsp after reset", 16'(rspCnt), 16'd0);
      applyStimulus(3'd1, 2'd0, 16'h0056, 8'h00, 8'h00, 16'h0000);

      @(negedge CLK);
      sel = 1'b1;
      #1;
      checkOutput("b2b ready0", {15'd0, obsReady}, 16'd1);
      cmdValid = 1'b1; cmdOp = 3'd0; cmdWdata = 16'h00A5;
      rspCnt = 0; readyCyc = -1; rsp1 = -1; rsp2 = -1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            checkOutput("b2b first addr", {12'd0, obsAddr}, 16'h0008);
            cmdOp = 3'd7;
         end
         if (c == 6) begin
            checkOutput("b2b second addr", {12'd0, obsAddr}, 16'h000C);
            checkOutput("b2b second data", {7'd0, obsOe, obsDout}, 16'h0100);
            cmdValid = 1'b0;
         end
         if (obsRsp) begin
            rspCnt++;
            if (rsp1 < 0) rsp1 = c;
            else if (rsp2 < 0) rsp2 = c;
         end
         if (obsReady && cmdValid && readyCyc < 0) readyCyc = c;
      end
      checkOutput("b2b rsp count", 16'(rspCnt), 16'd2);
      checkOutput("b2b rsp1 cycle", 16'(rsp1), 16'd4);
      checkOutput("b2b rsp2 cycle", 16'(rsp2), 16'd9);
      checkOutput("b2b ready cycle", 16'(readyCyc), 16'd5);

      for (int i = 0; i < 30; i++) begin
         sel = 1'($urandom_range(0, 1));
         rop = 3'($urandom_range(0, 7));
         rlo = 8'($urandom);
         rhi = 8'($urandom);
         applyStimulus(rop, 2'($urandom), 16'($urandom), rlo, rhi, expRdata(rop, rlo, rhi));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
